// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipelined control unit for the 16-bit WISC core.
// Decodes opcodes, carries controls to EX/MEM/WB, resolves hazards.
module ctrl_pipe #(
  parameter int INSTR_W = 16,
  parameter int OPC_W   = 4,
  parameter int RADDR_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               instr_valid,
  input  logic               flush,
  input  logic               mem_ready,
  output logic               id_reg_rt_src,
  output logic               stall_if,
  output logic               ex_valid,
  output logic [2:0]         ex_alu_op,
  output logic               ex_alu_src,
  output logic               ex_sign_ext_sel,
  output logic               ex_branch,
  output logic               ex_call,
  output logic               ex_rtrn,
  output logic               ex_data_reg,
  output logic               ex_stack_reg,
  output logic               ex_load_half,
  output logic               ex_half_spec,
  output logic               mem_valid,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               mem_reg_to_mem,
  output logic               wb_valid,
  output logic               wb_reg_write,
  output logic [RADDR_W-1:0] wb_dst,
  output logic               halted,
  output logic [CNT_W-1:0]   retire_cnt
);

  localparam logic [3:0] OP_INC  = 4'h1;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_LHB  = 4'hA;
  localparam logic [3:0] OP_LLB  = 4'hB;
  localparam logic [3:0] OP_B    = 4'hC;
  localparam logic [3:0] OP_CALL = 4'hD;
  localparam logic [3:0] OP_RET  = 4'hE;
  localparam logic [3:0] OP_ERR  = 4'hF;

  typedef struct packed {
    logic               valid;
    logic [2:0]         alu_op;
    logic               alu_src;
    logic               sign_ext_sel;
    logic               branch;
    logic               call;
    logic               rtrn;
    logic               data_reg;
    logic               stack_reg;
    logic               load_half;
    logic               half_spec;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               reg_to_mem;
    logic               reg_write;
    logic               halt;
    logic [RADDR_W-1:0] rd;
  } ex_t;

  typedef struct packed {
    logic               valid;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               reg_to_mem;
    logic               reg_write;
    logic               halt;
    logic [RADDR_W-1:0] rd;
  } mem_t;

  typedef struct packed {
    logic               valid;
    logic               reg_write;
    logic [RADDR_W-1:0] rd;
  } wb_t;

  logic [OPC_W-1:0]   opc;
  logic [3:0]         op;
  logic [RADDR_W-1:0] rd_f, rs_f, rt_f, rd2_f;
  ex_t                dec;
  logic               rt_src;
  logic               freeze, load_use, accept;

  ex_t              ex_q, ex_d;
  mem_t             mem_q, mem_d;
  wb_t              wb_q, wb_d;
  logic             hp_q, hp_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign opc   = instr_in[INSTR_W-1 -: OPC_W];
  assign op    = opc[3:0];
  assign rd_f  = instr_in[3*RADDR_W-1 -: RADDR_W];
  assign rs_f  = instr_in[2*RADDR_W-1 -: RADDR_W];
  assign rt_f  = instr_in[RADDR_W-1:0];
  assign rd2_f = rt_src ? rd_f : rt_f;

  // Opcode decode into the full control bundle.
  always_comb begin
    dec           = '0;
    dec.valid     = 1'b1;
    dec.rd        = rd_f;
    dec.alu_op    = op[2:0];
    dec.reg_write = 1'b1;
    rt_src        = 1'b0;
    unique case (op)
      OP_INC: dec.alu_src = 1'b1;
      OP_LW: begin
        dec.alu_op       = 3'b000;
        dec.alu_src      = 1'b1;
        dec.sign_ext_sel = 1'b1;
        dec.data_reg     = 1'b1;
        dec.mem_read     = 1'b1;
        dec.mem_to_reg   = 1'b1;
      end
      OP_SW: begin
        dec.alu_op       = 3'b000;
        dec.alu_src      = 1'b1;
        dec.sign_ext_sel = 1'b1;
        dec.data_reg     = 1'b1;
        dec.mem_write    = 1'b1;
        dec.reg_to_mem   = 1'b1;
        dec.reg_write    = 1'b0;
        rt_src           = 1'b1;
      end
      OP_LHB: begin
        dec.load_half = 1'b1;
        rt_src        = 1'b1;
      end
      OP_LLB: begin
        dec.load_half = 1'b1;
        dec.half_spec = 1'b1;
        rt_src        = 1'b1;
      end
      OP_B: begin
        dec.branch       = 1'b1;
        dec.sign_ext_sel = 1'b1;
        dec.reg_write    = 1'b0;
      end
      OP_CALL: begin
        dec.alu_op     = 3'b000;
        dec.call       = 1'b1;
        dec.stack_reg  = 1'b1;
        dec.mem_write  = 1'b1;
        dec.reg_to_mem = 1'b1;
      end
      OP_RET: begin
        dec.alu_op    = 3'b000;
        dec.rtrn      = 1'b1;
        dec.stack_reg = 1'b1;
        dec.mem_read  = 1'b1;
      end
      OP_ERR: begin
        dec.halt      = 1'b1;
        dec.reg_write = 1'b0;
      end
      default: ;
    endcase
  end

  // Hazard detection and fetch stall; a flush overrides a load-use stall.
  always_comb begin
    freeze   = mem_q.valid & (mem_q.mem_read | mem_q.mem_write)
             & ~mem_ready;
    load_use = ex_q.valid & ex_q.mem_read & ex_q.reg_write
             & ((ex_q.rd == rs_f) | (ex_q.rd == rd2_f));
    stall_if = freeze | hp_q | halted_q | (load_use & ~flush);
    accept   = instr_valid & ~stall_if & ~flush;
  end

  // Next state of the stage registers, halt tracking and retire count.
  always_comb begin
    ex_d     = ex_q;
    mem_d    = mem_q;
    wb_d     = wb_q;
    hp_d     = hp_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    if (!freeze) begin
      ex_d = accept ? dec : '0;
      if (flush) begin
        mem_d = '0;
        hp_d  = hp_q & ~(ex_q.valid & ex_q.halt);
      end else begin
        mem_d.valid      = ex_q.valid;
        mem_d.mem_read   = ex_q.mem_read;
        mem_d.mem_write  = ex_q.mem_write;
        mem_d.mem_to_reg = ex_q.mem_to_reg;
        mem_d.reg_to_mem = ex_q.reg_to_mem;
        mem_d.reg_write  = ex_q.reg_write;
        mem_d.halt       = ex_q.halt;
        mem_d.rd         = ex_q.rd;
        hp_d             = hp_q | (accept & dec.halt);
      end
      wb_d.valid     = mem_q.valid;
      wb_d.reg_write = mem_q.reg_write;
      wb_d.rd        = mem_q.rd;
      halted_d       = halted_q | (mem_q.valid & mem_q.halt);
      cnt_d          = cnt_q + CNT_W'(wb_q.valid);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      hp_q     <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      ex_q     <= ex_d;
      mem_q    <= mem_d;
      wb_q     <= wb_d;
      hp_q     <= hp_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  assign id_reg_rt_src   = rt_src;
  assign ex_valid        = ex_q.valid;
  assign ex_alu_op       = ex_q.alu_op;
  assign ex_alu_src      = ex_q.alu_src;
  assign ex_sign_ext_sel = ex_q.sign_ext_sel;
  assign ex_branch       = ex_q.branch;
  assign ex_call         = ex_q.call;
  assign ex_rtrn         = ex_q.rtrn;
  assign ex_data_reg     = ex_q.data_reg;
  assign ex_stack_reg    = ex_q.stack_reg;
  assign ex_load_half    = ex_q.load_half;
  assign ex_half_spec    = ex_q.half_spec;
  assign mem_valid       = mem_q.valid;
  assign mem_read        = mem_q.mem_read;
  assign mem_write       = mem_q.mem_write;
  assign mem_to_reg      = mem_q.mem_to_reg;
  assign mem_reg_to_mem  = mem_q.reg_to_mem;
  assign wb_valid        = wb_q.valid;
  assign wb_reg_write    = wb_q.reg_write;
  assign wb_dst          = wb_q.rd;
  assign halted          = halted_q;
  assign retire_cnt      = cnt_q;

endmodule
